hq_frame_buffer: RTL and testbench

Ping-pong frame buffer at the output of the SOML Hq calculation stage. It captures the streamed complex Hq products (Q8.8, one per cycle) indexed by symbol hypothesis, H row and S column, and commits each complete set as a frame. It presents committed frames to the downstream metric/search stage through a random-access read port with an explicit release handshake. Two banks allow the producer to fill one frame while the consumer reads the other.

---
 rtl/hq_frame_buffer_pkg.sv | 17 +
 rtl/hq_frame_buffer_if.sv | 36 +++
 rtl/hq_frame_buffer_bank_ram.sv | 29 ++
 rtl/hq_frame_buffer.sv | 85 ++++++++
 tb/tb_hq_frame_buffer.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hq_frame_buffer_pkg.sv
// soml_pkg: shared constants and bank-state encoding for the SOML Hq path.
package soml_pkg;
    localparam int DW    = 16;
    localparam int FRAC  = 8;
    localparam int NUM_S = 16;
    localparam int AW    = $clog2(NUM_S) + 4;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        FULL
    } bank_state_t;

    function automatic int frame_words(input int num_s);
        return num_s * 16;
    endfunction
endpackage

// File: rtl/hq_frame_buffer_if.sv
// hq_frame_buffer_if: producer write stream and consumer read/release port of the Hq frame buffer.
interface hq_frame_buffer_if #(
    parameter int NUM_S = soml_pkg::NUM_S,
    parameter int DW    = soml_pkg::DW
);
    localparam int SW = $clog2(NUM_S);
    localparam int AW = SW + 4;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_hq_r;
    logic [DW-1:0] in_hq_i;
    logic [SW-1:0] in_si;
    logic [1:0]    in_row;
    logic [1:0]    in_col;
    logic          in_last;
    logic          frame_valid;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_hq_r;
    logic [DW-1:0] rd_hq_i;
    logic          rd_release;
    logic          err_len;

    modport master (
        output in_valid, in_hq_r, in_hq_i, in_si, in_row, in_col, in_last,
        output rd_en, rd_addr, rd_release,
        input  in_ready, frame_valid, rd_hq_r, rd_hq_i, err_len
    );

    modport slave (
        input  in_valid, in_hq_r, in_hq_i, in_si, in_row, in_col, in_last,
        input  rd_en, rd_addr, rd_release,
        output in_ready, frame_valid, rd_hq_r, rd_hq_i, err_len
    );
endinterface

// File: rtl/hq_frame_buffer_bank_ram.sv
// hq_bank_ram: simple dual-port RAM, one write port and one registered read port.
module hq_bank_ram #(
    parameter int AW = 9,
    parameter int W  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [2**AW];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/hq_frame_buffer.sv
// hq_frame_buffer: ping-pong buffer of streamed Hq products, committed as frames
// and served to the metric/search stage through a random-access read/release port.
module hq_frame_buffer #(
    parameter int NUM_S = soml_pkg::NUM_S,
    parameter int DW    = soml_pkg::DW
) (
    input logic         clk,
    input logic         rst,
    hq_frame_buffer_if.slave bus
);
    import soml_pkg::*;

    localparam int AW = $clog2(NUM_S) + 4;
    localparam int CW = AW + 1;
    localparam int FRAME_WORDS = frame_words(NUM_S);

    bank_state_t     r_state [2];
    bank_state_t     w_state_nx [2];
    logic            r_wp;
    logic            r_rp;
    logic            r_err;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_ready;
    logic            w_wr;
    logic            w_commit;
    logic            w_fv;
    logic            w_rel;
    logic [2*DW-1:0] w_rdata;

    assign w_ready   = r_state[r_wp] != FULL;
    assign w_wr      = bus.in_valid & w_ready;
    assign w_commit  = w_wr & bus.in_last;
    assign w_fv      = r_state[r_rp] == FULL;
    assign w_rel     = bus.rd_release & w_fv;
    assign w_cnt_inc = r_cnt + 1'b1;

    // Commit needs state[wp]!=FULL and release needs state[rp]==FULL, so they never hit the same bank.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_state_nx[b] = (w_rel && r_rp == 1'(b)) ? EMPTY :
                            (w_wr && r_wp == 1'(b))  ? (w_commit ? FULL : FILL) :
                            r_state[b];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state[0] <= EMPTY;
            r_state[1] <= EMPTY;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state[0] <= w_state_nx[0];
            r_state[1] <= w_state_nx[1];
            r_wp       <= r_wp ^ w_commit;
            r_rp       <= r_rp ^ w_rel;
            if (w_wr) r_cnt <= w_commit ? '0 : w_cnt_inc;
            if (w_commit && w_cnt_inc != CW'(FRAME_WORDS)) r_err <= 1'b1;
        end
    end

    // Bank select is the RAM address MSB on both ports.
    hq_bank_ram #(
        .AW (AW + 1),
        .W  (2 * DW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr),
        .i_waddr ({r_wp, bus.in_si, bus.in_row, bus.in_col}),
        .i_wdata ({bus.in_hq_r, bus.in_hq_i}),
        .i_re    (bus.rd_en),
        .i_raddr ({r_rp, bus.rd_addr}),
        .o_rdata (w_rdata)
    );

    assign bus.in_ready    = w_ready;
    assign bus.frame_valid = w_fv;
    assign bus.rd_hq_r     = w_rdata[2*DW-1:DW];
    assign bus.rd_hq_i     = w_rdata[DW-1:0];
    assign bus.err_len     = r_err;
endmodule

// File: tb/tb_hq_frame_buffer.sv
// tb_hq_frame_buffer: directed scenarios for the Hq ping-pong frame buffer.
module tb_hq_frame_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hq_frame_buffer_if ifc ();

    hq_frame_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    function automatic logic [15:0] ev_r(input int a, input int off);
        return 16'(a + off);
    endfunction

    function automatic logic [15:0] ev_i(input int a, input int off);
        return 16'(-(a + off));
    endfunction

    task automatic idle();
        ifc.in_valid   = 1'b0;
        ifc.in_last    = 1'b0;
        ifc.in_hq_r    = '0;
        ifc.in_hq_i    = '0;
        ifc.in_si      = '0;
        ifc.in_row     = '0;
        ifc.in_col     = '0;
        ifc.rd_en      = 1'b0;
        ifc.rd_addr    = '0;
        ifc.rd_release = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drive_word(input int a, input int off, input bit last);
        ifc.in_valid = 1'b1;
        ifc.in_last  = last;
        ifc.in_hq_r  = ev_r(a, off);
        ifc.in_hq_i  = ev_i(a, off);
        ifc.in_si    = a[7:4];
        ifc.in_row   = a[3:2];
        ifc.in_col   = a[1:0];
    endtask

    task automatic push(input int a, input int off, input bit last, output int stalls);
        int n;
        n = 0;
        drive_word(a, off, last);
        while (!ifc.in_ready && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        if (n == 50) begin
            checks++;
            errors++;
            $display("FAIL push_timeout addr=%0d in_ready stuck at 0 for %0d cycles, required 1", a, n);
        end else begin
            @(posedge clk);
            #1;
        end
        stalls = n;
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
    endtask

    task automatic stream(input int first, input int lst, input int off, input bit do_last, output int stalls);
        int s;
        stalls = 0;
        for (int a = first; a <= lst; a++) begin
            push(a, off, do_last && a == lst, s);
            stalls += s;
        end
    endtask

    task automatic rd(input int a, output logic [15:0] r, output logic [15:0] i);
        ifc.rd_en   = 1'b1;
        ifc.rd_addr = 8'(a);
        @(posedge clk);
        #1 ifc.rd_en = 1'b0;
        r = ifc.rd_hq_r;
        i = ifc.rd_hq_i;
    endtask

    task automatic release_frame();
        ifc.rd_release = 1'b1;
        @(posedge clk);
        #1 ifc.rd_release = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        #2;
        checks++;
        if (ifc.in_ready !== 1'b1 || ifc.frame_valid !== 1'b0 || ifc.err_len !== 1'b0 ||
            ifc.rd_hq_r !== 16'h0 || ifc.rd_hq_i !== 16'h0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b fv=%b err=%b r=%h i=%h required 1 0 0 0000 0000",
                     ifc.in_ready, ifc.frame_valid, ifc.err_len, ifc.rd_hq_r, ifc.rd_hq_i);
        end
        do_reset();
    endtask

    task automatic test_full_frame();
        int s;
        logic [15:0] r, i;
        do_reset();
        stream(0, 254, 0, 1'b0, s);
        checks++;
        if (ifc.frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL fv_before_last got %b required 0", ifc.frame_valid);
        end
        push(255, 0, 1'b1, s);
        checks++;
        if (ifc.frame_valid !== 1'b1 || ifc.err_len !== 1'b0) begin
            errors++;
            $display("FAIL fv_after_last got fv=%b err=%b required fv=1 err=0", ifc.frame_valid, ifc.err_len);
        end
        for (int a = 0; a < 256; a++) begin
            rd(a, r, i);
            checks++;
            if (r !== ev_r(a, 0) || i !== ev_i(a, 0)) begin
                errors++;
                $display("FAIL full_read addr=%0d got r=%h i=%h required r=%h i=%h", a, r, i, ev_r(a, 0), ev_i(a, 0));
            end
        end
        release_frame();
        checks++;
        if (ifc.frame_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_release got fv=%b rdy=%b required fv=0 rdy=1", ifc.frame_valid, ifc.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int s1, s2, s;
        logic [15:0] r, i;
        do_reset();
        stream(0, 255, 1000, 1'b1, s1);
        stream(0, 255, 2000, 1'b1, s2);
        checks++;
        if (s1 + s2 !== 0) begin
            errors++;
            $display("FAIL b2b_stalls got %0d required 0", s1 + s2);
        end
        drive_word(0, 3000, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ifc.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL third_frame_stall got rdy=%b required 0", ifc.in_ready);
        end
        release_frame();
        checks++;
        if (ifc.in_ready !== 1'b1 || ifc.frame_valid !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release got rdy=%b fv=%b required 1 1", ifc.in_ready, ifc.frame_valid);
        end
        push(0, 3000, 1'b0, s);
        stream(1, 255, 3000, 1'b1, s);
        checks++;
        if (s !== 0 || ifc.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL third_frame_done got stalls=%0d rdy=%b required 0 0", s, ifc.in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            rd(k * 127 + 1, r, i);
            checks++;
            if (r !== ev_r(k * 127 + 1, 2000) || i !== ev_i(k * 127 + 1, 2000)) begin
                errors++;
                $display("FAIL b2b_read_frame2 addr=%0d got r=%h i=%h required r=%h i=%h",
                         k * 127 + 1, r, i, ev_r(k * 127 + 1, 2000), ev_i(k * 127 + 1, 2000));
            end
        end
        release_frame();
        for (int k = 0; k < 3; k++) begin
            rd(k * 127 + 1, r, i);
            checks++;
            if (ifc.frame_valid !== 1'b1 || r !== ev_r(k * 127 + 1, 3000) || i !== ev_i(k * 127 + 1, 3000)) begin
                errors++;
                $display("FAIL b2b_read_frame3 addr=%0d got fv=%b r=%h i=%h required fv=1 r=%h i=%h",
                         k * 127 + 1, ifc.frame_valid, r, i, ev_r(k * 127 + 1, 3000), ev_i(k * 127 + 1, 3000));
            end
        end
    endtask

    task automatic test_short_frame();
        int s;
        logic [15:0] r, i;
        do_reset();
        stream(0, 100, 500, 1'b1, s);
        checks++;
        if (ifc.frame_valid !== 1'b1 || ifc.err_len !== 1'b1) begin
            errors++;
            $display("FAIL short_commit got fv=%b err=%b required 1 1", ifc.frame_valid, ifc.err_len);
        end
        rd(100, r, i);
        checks++;
        if (r !== ev_r(100, 500) || i !== ev_i(100, 500)) begin
            errors++;
            $display("FAIL short_read got r=%h i=%h required r=%h i=%h", r, i, ev_r(100, 500), ev_i(100, 500));
        end
        release_frame();
        stream(0, 255, 600, 1'b1, s);
        rd(200, r, i);
        checks++;
        if (ifc.err_len !== 1'b1 || ifc.frame_valid !== 1'b1 || r !== ev_r(200, 600) || i !== ev_i(200, 600)) begin
            errors++;
            $display("FAIL err_sticky got err=%b fv=%b r=%h i=%h required 1 1 %h %h",
                     ifc.err_len, ifc.frame_valid, r, i, ev_r(200, 600), ev_i(200, 600));
        end
        do_reset();
        checks++;
        if (ifc.err_len !== 1'b0) begin
            errors++;
            $display("FAIL err_clear_on_reset got %b required 0", ifc.err_len);
        end
    endtask

    task automatic test_release_commit();
        int s;
        logic [15:0] r, i;
        do_reset();
        stream(0, 255, 100, 1'b1, s);
        stream(0, 254, 300, 1'b0, s);
        ifc.rd_release = 1'b1;
        push(255, 300, 1'b1, s);
        ifc.rd_release = 1'b0;
        checks++;
        if (ifc.frame_valid !== 1'b1 || ifc.in_ready !== 1'b1 || ifc.err_len !== 1'b0) begin
            errors++;
            $display("FAIL rel_commit_state got fv=%b rdy=%b err=%b required 1 1 0",
                     ifc.frame_valid, ifc.in_ready, ifc.err_len);
        end
        rd(3, r, i);
        checks++;
        if (r !== ev_r(3, 300) || i !== ev_i(3, 300)) begin
            errors++;
            $display("FAIL rel_commit_read got r=%h i=%h required r=%h i=%h", r, i, ev_r(3, 300), ev_i(3, 300));
        end
    endtask

    task automatic test_reset_mid();
        int s;
        logic [15:0] r, i;
        do_reset();
        stream(0, 255, 0, 1'b1, s);
        rd(5, r, i);
        checks++;
        if (r !== ev_r(5, 0) || i !== ev_i(5, 0)) begin
            errors++;
            $display("FAIL pre_reset_read got r=%h i=%h required r=%h i=%h", r, i, ev_r(5, 0), ev_i(5, 0));
        end
        stream(0, 49, 900, 1'b0, s);
        drive_word(50, 900, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ifc.in_ready !== 1'b1 || ifc.frame_valid !== 1'b0 || ifc.err_len !== 1'b0 ||
            ifc.rd_hq_r !== 16'h0 || ifc.rd_hq_i !== 16'h0) begin
            errors++;
            $display("FAIL async_reset got rdy=%b fv=%b err=%b r=%h i=%h required 1 0 0 0000 0000",
                     ifc.in_ready, ifc.frame_valid, ifc.err_len, ifc.rd_hq_r, ifc.rd_hq_i);
        end
        idle();
        @(posedge clk);
        #1 rst = 1'b0;
        stream(0, 255, 400, 1'b1, s);
        for (int k = 0; k < 3; k++) begin
            rd(k * 100 + 7, r, i);
            checks++;
            if (ifc.frame_valid !== 1'b1 || ifc.err_len !== 1'b0 ||
                r !== ev_r(k * 100 + 7, 400) || i !== ev_i(k * 100 + 7, 400)) begin
                errors++;
                $display("FAIL post_reset_read addr=%0d got fv=%b err=%b r=%h i=%h required 1 0 %h %h",
                         k * 100 + 7, ifc.frame_valid, ifc.err_len, r, i, ev_r(k * 100 + 7, 400), ev_i(k * 100 + 7, 400));
            end
        end
    endtask

    task automatic test_spurious_release();
        int s;
        logic [15:0] r, i;
        do_reset();
        release_frame();
        checks++;
        if (ifc.frame_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL spurious_release got fv=%b rdy=%b required 0 1", ifc.frame_valid, ifc.in_ready);
        end
        stream(0, 255, 700, 1'b1, s);
        rd(9, r, i);
        checks++;
        if (ifc.frame_valid !== 1'b1 || r !== ev_r(9, 700) || i !== ev_i(9, 700)) begin
            errors++;
            $display("FAIL spurious_then_frame got fv=%b r=%h i=%h required 1 %h %h",
                     ifc.frame_valid, r, i, ev_r(9, 700), ev_i(9, 700));
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_back_to_back();
        test_short_frame();
        test_release_commit();
        test_reset_mid();
        test_spurious_release();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
